// File: rtl/hamming_pkg.sv
// Shared definitions for the 64-bit SEC Hamming encoder/decoder pair.
// Codeword positions are numbered 1..71. Bit k of a codeword vector holds position k+1.
// Parity p_j sits at position 2^j. Data bits fill the remaining positions in ascending order.
package hamming_pkg;

    localparam int DATA_W = 64;
    localparam int CODE_W = DATA_W + 7;
    localparam int PAR_W  = 7;

    // Returns the codeword position (1-based) that holds data bit idx.
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p <= CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx && pos == 0) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    // Coverage mask for parity group j: every position whose index has bit j set.
    // The group includes the parity slot 2^j itself. The decoder can therefore XOR a
    // received word directly into a syndrome bit. The encoder zeroes the parity slots
    // beforehand, so the same mask yields the parity value.
    function automatic logic [CODE_W-1:0] par_mask(input int j);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int p = 1; p <= CODE_W; p++) begin
            if (((p >> j) & 1) != 0) m[p-1] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [CODE_W-1:0] PAR_MASK [PAR_W] = '{
        par_mask(0), par_mask(1), par_mask(2), par_mask(3),
        par_mask(4), par_mask(5), par_mask(6)
    };

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational parity/syndrome generator over a 71-bit codeword vector.
// With the parity slots zeroed, the outputs are the parity bits.
// With a received codeword, the outputs are the syndrome.
module hamming_parity_gen
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] vec,
    output logic [PAR_W-1:0]  parity
);

    // Reduce each coverage group to one even-parity bit.
    always_comb begin
        parity = '0;
        for (int j = 0; j < PAR_W; j++) begin
            parity[j] = ^(vec & PAR_MASK[j]);
        end
    end

endmodule

// File: rtl/hamming_encoder_64bit.sv
// Two-stage pipelined SEC Hamming encoder, 64 data bits to a 71-bit codeword.
// Stage 1 scatters data into codeword positions. Stage 2 inserts the parity bits.
// A single advance signal moves both stages together, so at most two words are in flight.
// Optional macro HAMMING_ERR_INJECT_EN adds err_inject/err_pos for flipping one codeword
// position, which lets a bench exercise the downstream decoder.
module hamming_encoder_64bit
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic              err_inject,
    input  logic [6:0]        err_pos,
`endif
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CODE_W-1:0] encoded_out,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  word_count
);

    logic              adv;
    logic              accept;
    logic [CODE_W-1:0] scatter;
    logic [CODE_W-1:0] s1_vec;
    logic              s1_valid;
    logic [PAR_W-1:0]  parity;
    logic [CODE_W-1:0] code_clean;
    logic [CODE_W-1:0] code_next;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && enable;
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < DATA_W; i++) begin : g_data
        assign scatter[data_pos(i)-1] = data_in[i];
    end

    for (genvar j = 0; j < PAR_W; j++) begin : g_pslot
        assign scatter[(1 << j) - 1] = 1'b0;
    end

`ifdef HAMMING_ERR_INJECT_EN
    logic              s1_err;
    logic [6:0]        s1_pos;
    logic [CODE_W-1:0] flip_mask;

    // Error request travels with its word through stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_err <= 1'b0;
            s1_pos <= '0;
        end else if (adv) begin
            s1_err <= accept && err_inject;
            s1_pos <= err_pos;
        end
    end

    // One-hot flip on a legal position; 0 and 72..127 leave the codeword clean.
    always_comb begin
        flip_mask = '0;
        if (s1_err && s1_pos != 7'd0 && s1_pos <= 7'(CODE_W)) begin
            flip_mask[s1_pos - 7'd1] = 1'b1;
        end
    end

    assign code_next = code_clean ^ flip_mask;
`else
    assign code_next = code_clean;
`endif

    // Stage 1: capture the scattered word, or a bubble when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_vec   <= '0;
        end else if (adv) begin
            s1_valid <= accept;
            s1_vec   <= scatter;
        end
    end

    hamming_parity_gen u_parity (
        .vec    (s1_vec),
        .parity (parity)
    );

    // Drop the computed parity bits into their power-of-two slots.
    always_comb begin
        code_clean = s1_vec;
        for (int j = 0; j < PAR_W; j++) begin
            code_clean[(1 << j) - 1] = parity[j];
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            encoded_out <= '0;
        end else if (adv) begin
            out_valid   <= s1_valid;
            encoded_out <= code_next;
        end
    end

    // Count delivered codewords; wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
        end else if (out_valid && out_ready) begin
            word_count <= word_count + 1'b1;
        end
    end

endmodule
